// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx : I2S master receiver with an AXI-Stream sample output.
//
// The block generates the I2S bit clock (sclk_out) and word select
// (lrclk_out) from aud_mclk. It captures AUD_WIDTH bits MSB first, one sclk
// after each word-select change. Each completed sample is presented on a
// single-entry AXI-Stream output register.
//
// Ports
//   aud_mclk           in   master clock, all logic on its rising edge
//   aud_mresetn        in   asynchronous active-low reset
//   i2s_en             in   receiver enable; low parks the I2S bus and clears
//                           the framing state
//   sclk_out           out  I2S bit clock, MCLK/SCLK = 2*SCLK_DIVIDER_VALUE
//   lrclk_out          out  word select, 0 = left, 1 = right
//   sdata_in           in   serial data, already synchronous to aud_mclk
//   m_axis_aud_tdata   out  sample placed at bits [AUD_WIDTH+3:4], rest zero
//   m_axis_aud_tid     out  channel id, 0 = left, 1 = right
//   m_axis_aud_tvalid  out  AXI-Stream valid
//   m_axis_aud_tready  in   AXI-Stream ready
//   ovf_pulse          out  one-cycle pulse when a completed sample is dropped
//
// AUD_WIDTH must be between 2 and 31. AUD_WIDTH+4 must not exceed
// AXI_STREAM_DATA_WIDTH.
// -----------------------------------------------------------------------------
module i2s_rx #(
   parameter int AUD_WIDTH             = 24,
   parameter int AXI_STREAM_DATA_WIDTH = 32,
   parameter int AXI_STREAM_TID_WIDTH  = 3,
   parameter int SCLK_DIVIDER_VALUE    = 6
) (
   input  logic                             aud_mclk,
   input  logic                             aud_mresetn,
   input  logic                             i2s_en,
   output logic                             sclk_out,
   output logic                             lrclk_out,
   input  logic                             sdata_in,
   output logic [AXI_STREAM_DATA_WIDTH-1:0] m_axis_aud_tdata,
   output logic [AXI_STREAM_TID_WIDTH-1:0]  m_axis_aud_tid,
   output logic                             m_axis_aud_tvalid,
   input  logic                             m_axis_aud_tready,
   output logic                             ovf_pulse
);

   localparam int DIV_W = (SCLK_DIVIDER_VALUE > 1) ? $clog2(SCLK_DIVIDER_VALUE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIVIDER_VALUE - 1);
   localparam logic [4:0]       LAST_SLOT = 5'(AUD_WIDTH);
   localparam int               LSB_POS   = 4;

   // framing state
   logic [DIV_W-1:0]     div_cnt_reg, div_cnt_next;
   logic                 sclk_reg, sclk_next;
   logic                 lrclk_reg, lrclk_next;
   logic [4:0]           bit_cnt_reg, bit_cnt_next;
   logic [AUD_WIDTH-1:0] shift_reg, shift_next;
   logic                 word_done_reg, word_done_next;
   logic                 word_ch_reg, word_ch_next;

   // output register
   logic [AXI_STREAM_DATA_WIDTH-1:0] tdata_reg, tdata_next;
   logic [AXI_STREAM_TID_WIDTH-1:0]  tid_reg, tid_next;
   logic                             tvalid_reg, tvalid_next;
   logic                             ovf_reg, ovf_next;

   logic                             div_tick;
   logic                             sclk_rise;
   logic                             sclk_fall;
   logic                             capture;
   logic [AXI_STREAM_DATA_WIDTH-1:0] sample_word;

   assign div_tick  = (div_cnt_reg == DIV_LAST);
   assign sclk_rise = i2s_en && div_tick && !sclk_reg;
   assign sclk_fall = i2s_en && div_tick &&  sclk_reg;
   // Slot 0 of each half-frame is the I2S one-bit delay; slots above
   // AUD_WIDTH are padding.
   assign capture   = sclk_rise && (bit_cnt_reg != 5'd0) && (bit_cnt_reg <= LAST_SLOT);

   // Place the captured sample at bit 4 upward; every other bit is zero.
   generate
      for (genvar gi = 0; gi < AXI_STREAM_DATA_WIDTH; gi++) begin : g_place
         if (gi >= LSB_POS && gi < LSB_POS + AUD_WIDTH) begin : g_aud
            assign sample_word[gi] = shift_reg[gi - LSB_POS];
         end else begin : g_zero
            assign sample_word[gi] = 1'b0;
         end
      end
   endgenerate

   // Framing: clock divider, bit clock, word select and shift register.
   always_comb begin
      div_cnt_next   = div_cnt_reg;
      sclk_next      = sclk_reg;
      lrclk_next     = lrclk_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      word_ch_next   = word_ch_reg;
      // A word completes on the rise that samples its LSB. A completed
      // word is loaded on the next cycle even if the enable drops meanwhile.
      word_done_next = capture && (bit_cnt_reg == LAST_SLOT);

      if (!i2s_en) begin
         div_cnt_next = '0;
         sclk_next    = 1'b0;
         lrclk_next   = 1'b0;
         bit_cnt_next = '0;
         shift_next   = '0;
      end else begin
         if (div_tick) begin
            div_cnt_next = '0;
            sclk_next    = ~sclk_reg;
         end else begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
         end

         // The bit counter wraps naturally from 31 to 0. The word select
         // changes on that same falling edge.
         if (sclk_fall) begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd31) begin
               lrclk_next = ~lrclk_reg;
            end
         end

         if (capture) begin
            shift_next   = {shift_reg[AUD_WIDTH-2:0], sdata_in};
            word_ch_next = lrclk_reg;
         end
      end
   end

   // Output register. A held word has priority over a newly completed one
   // unless it is being accepted in the same cycle.
   always_comb begin
      tdata_next  = tdata_reg;
      tid_next    = tid_reg;
      tvalid_next = tvalid_reg;
      ovf_next    = 1'b0;

      if (word_done_reg) begin
         if (tvalid_reg && !m_axis_aud_tready) begin
            ovf_next = 1'b1;
         end else begin
            tdata_next  = sample_word;
            tid_next    = AXI_STREAM_TID_WIDTH'(word_ch_reg);
            tvalid_next = 1'b1;
         end
      end else if (tvalid_reg && m_axis_aud_tready) begin
         tvalid_next = 1'b0;
      end
   end

   always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
      if (!aud_mresetn) begin
         div_cnt_reg   <= '0;
         sclk_reg      <= 1'b0;
         lrclk_reg     <= 1'b0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         word_done_reg <= 1'b0;
         word_ch_reg   <= 1'b0;
         tdata_reg     <= '0;
         tid_reg       <= '0;
         tvalid_reg    <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         div_cnt_reg   <= div_cnt_next;
         sclk_reg      <= sclk_next;
         lrclk_reg     <= lrclk_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         word_done_reg <= word_done_next;
         word_ch_reg   <= word_ch_next;
         tdata_reg     <= tdata_next;
         tid_reg       <= tid_next;
         tvalid_reg    <= tvalid_next;
         ovf_reg       <= ovf_next;
      end
   end

   assign sclk_out          = sclk_reg;
   assign lrclk_out         = lrclk_reg;
   assign m_axis_aud_tdata  = tdata_reg;
   assign m_axis_aud_tid    = tid_reg;
   assign m_axis_aud_tvalid = tvalid_reg;
   assign ovf_pulse         = ovf_reg;

endmodule
